// File: rtl/led_cmd_pkg.sv
// Shared types and constants for the LED command sequencer.
// Characters are host command codes; patterns are {led1, led2}, active-low.
package led_cmd_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } seqState_t;

  localparam logic [7:0] CHAR_A = 8'h41;
  localparam logic [7:0] CHAR_B = 8'h42;
  localparam logic [7:0] CHAR_C = 8'h43;

  localparam logic [1:0] PAT_A   = 2'b01;
  localparam logic [1:0] PAT_B   = 2'b10;
  localparam logic [1:0] PAT_C   = 2'b00;
  localparam logic [1:0] PAT_OFF = 2'b11;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with an exact occupancy count.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] memR [DEPTH];
  logic [AW-1:0]    wrPtrR;
  logic [AW-1:0]    rdPtrR;
  logic [CW-1:0]    countR;
  logic             doPushS;
  logic             doPopS;

  assign full    = (countR == CW'(DEPTH));
  assign empty   = (countR == CW'(0));
  assign count   = countR;
  assign popData = memR[rdPtrR];
  assign doPopS  = pop && !empty;
  assign doPushS = push && (!full || doPopS);

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (doPushS) begin
      memR[wrPtrR] <= pushData;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      wrPtrR <= AW'(0);
      rdPtrR <= AW'(0);
      countR <= CW'(0);
    end else begin
      if (doPushS) begin
        wrPtrR <= wrPtrR + AW'(1);
      end
      if (doPopS) begin
        rdPtrR <= rdPtrR + AW'(1);
      end
      case ({doPushS, doPopS})
        2'b10:   countR <= countR + CW'(1);
        2'b01:   countR <= countR - CW'(1);
        default: countR <= countR;
      endcase
    end
  end

endmodule

// File: rtl/led_cmd_sequencer.sv
// Assembles host nibbles into command characters, queues them, and plays each
// one on two active-low LEDs for HOLD_CYCLES clocks, back-to-back.
module led_cmd_sequencer
  import led_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 1000,
  parameter int CNT_W       = 16
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        startFlag,
  input  logic                        readFlag,
  input  logic [3:0]                  dataIn,
  output logic                        led1,
  output logic                        led2,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifoCount,
  output logic                        overflow
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  seqState_t    stateR;
  seqState_t    nextStateS;
  logic         phaseHighR;
  logic [3:0]   hiNibR;
  logic         pushS;
  logic [7:0]   pushDataS;
  logic         popS;
  logic [7:0]   popDataS;
  logic         fullS;
  logic         emptyS;
  logic [CNT_W-1:0] holdCntR;
  logic [1:0]   ledsR;
  logic         overflowR;

  function automatic logic [1:0] decodeChar(input logic [7:0] c);
    case (c)
      CHAR_A:  return PAT_A;
      CHAR_B:  return PAT_B;
      CHAR_C:  return PAT_C;
      default: return PAT_OFF;
    endcase
  endfunction

  cmd_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) uFifo (
    .clk     (clk),
    .resetN  (resetN),
    .push    (pushS),
    .pushData(pushDataS),
    .pop     (popS),
    .popData (popDataS),
    .full    (fullS),
    .empty   (emptyS),
    .count   (fifoCount)
  );

  // A low nibble completes a character unless startFlag resynchronises the phase.
  always_comb begin
    pushS     = 1'b0;
    pushDataS = {hiNibR, dataIn};
    if (readFlag && !startFlag && !phaseHighR) begin
      pushS = 1'b1;
    end else begin
      pushS = 1'b0;
    end
  end

  // Nibble phase tracking; a startFlag with readFlag takes dataIn as the new high nibble.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      phaseHighR <= 1'b1;
      hiNibR     <= 4'h0;
    end else if (startFlag) begin
      phaseHighR <= !readFlag;
      hiNibR     <= readFlag ? dataIn : 4'h0;
    end else if (readFlag) begin
      phaseHighR <= !phaseHighR;
      hiNibR     <= phaseHighR ? dataIn : hiNibR;
    end else begin
      phaseHighR <= phaseHighR;
      hiNibR     <= hiNibR;
    end
  end

  // Next-state and pop decision.
  always_comb begin
    nextStateS = stateR;
    popS       = 1'b0;
    case (stateR)
      IDLE: begin
        if (!emptyS) begin
          popS       = 1'b1;
          nextStateS = HOLD;
        end else begin
          nextStateS = IDLE;
        end
      end
      HOLD: begin
        if (holdCntR != CNT_W'(0)) begin
          nextStateS = HOLD;
        end else if (!emptyS) begin
          popS       = 1'b1;
          nextStateS = HOLD;
        end else begin
          nextStateS = IDLE;
        end
      end
      default: begin
        nextStateS = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      stateR <= IDLE;
    end else begin
      stateR <= nextStateS;
    end
  end

  // LED pattern and hold counter; a pop reloads both so there is no off gap.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      holdCntR <= CNT_W'(0);
      ledsR    <= PAT_OFF;
    end else if (popS) begin
      holdCntR <= HOLD_LOAD;
      ledsR    <= decodeChar(popDataS);
    end else if (stateR == HOLD && holdCntR != CNT_W'(0)) begin
      holdCntR <= holdCntR - CNT_W'(1);
      ledsR    <= ledsR;
    end else if (stateR == HOLD) begin
      holdCntR <= holdCntR;
      ledsR    <= PAT_OFF;
    end else begin
      holdCntR <= holdCntR;
      ledsR    <= ledsR;
    end
  end

  // Sticky drop flag: full FIFO with no simultaneous pop to make room.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      overflowR <= 1'b0;
    end else begin
      overflowR <= overflowR | (pushS & fullS & ~popS);
    end
  end

  assign led1     = ledsR[1];
  assign led2     = ledsR[0];
  assign busy     = (stateR == HOLD);
  assign overflow = overflowR;

endmodule

// File: tb/tb_led_cmd_sequencer.sv
// Scoreboard bench: a short-hold instance for sequencing/latency and a
// long-hold instance for overflow, both driven from the same host inputs.
module tb_led_cmd_sequencer;

  localparam int HOLD_A = 5;
  localparam int HOLD_B = 100;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       startFlag = 1'b0;
  logic       readFlag = 1'b0;
  logic [3:0] dataIn = 4'h0;

  logic       led1A, led2A, busyA, ovfA;
  logic [2:0] cntA;
  logic       led1B, led2B, busyB, ovfB;
  logic [2:0] cntB;

  int checks = 0;
  int errors = 0;

  logic [1:0] expQ[$];
  logic [1:0] curExp = 2'b11;
  int         slotCnt = 0;
  logic       prevBusy = 1'b0;
  logic       monEn = 1'b0;

  always #5 clk = ~clk;

  led_cmd_sequencer #(.FIFO_DEPTH(4), .HOLD_CYCLES(HOLD_A), .CNT_W(16)) dutA (
    .clk(clk), .resetN(resetN), .startFlag(startFlag), .readFlag(readFlag),
    .dataIn(dataIn), .led1(led1A), .led2(led2A), .busy(busyA),
    .fifoCount(cntA), .overflow(ovfA)
  );

  led_cmd_sequencer #(.FIFO_DEPTH(4), .HOLD_CYCLES(HOLD_B), .CNT_W(16)) dutB (
    .clk(clk), .resetN(resetN), .startFlag(startFlag), .readFlag(readFlag),
    .dataIn(dataIn), .led1(led1B), .led2(led2B), .busy(busyB),
    .fifoCount(cntB), .overflow(ovfB)
  );

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] expPat(input logic [7:0] c);
    case (c)
      8'h41:   return 2'b01;
      8'h42:   return 2'b10;
      8'h43:   return 2'b00;
      default: return 2'b11;
    endcase
  endfunction

  task automatic sendNib(input logic [3:0] n);
    @(negedge clk);
    startFlag = 1'b0;
    readFlag  = 1'b1;
    dataIn    = n;
  endtask

  // Leaves the low nibble driven so consecutive calls stream one nibble per cycle.
  task automatic sendChar(input logic [7:0] c, input bit track);
    sendNib(c[7:4]);
    sendNib(c[3:0]);
    if (track) expQ.push_back(expPat(c));
  endtask

  task automatic idleIn();
    @(negedge clk);
    readFlag  = 1'b0;
    startFlag = 1'b0;
  endtask

  task automatic doReset();
    monEn  = 1'b0;
    resetN = 1'b0;
    readFlag = 1'b0;
    startFlag = 1'b0;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    expQ.delete();
    slotCnt  = 0;
    prevBusy = 1'b0;
    monEn    = 1'b1;
  endtask

  // Display monitor for instance A: each busy slot must last HOLD_A cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (monEn) begin
        if (busyA) begin
          if (slotCnt == 0) begin
            checkEq("slotAvail", {31'd0, expQ.size() > 0}, 32'd1);
            if (expQ.size() > 0) curExp = expQ.pop_front();
          end
          checkEq("ledPat", {30'd0, led1A, led2A}, {30'd0, curExp});
          slotCnt = (slotCnt == HOLD_A - 1) ? 0 : slotCnt + 1;
        end else begin
          if (prevBusy) checkEq("holdLen", slotCnt, 32'd0);
          checkEq("idleLed", {30'd0, led1A, led2A}, 32'd3);
          slotCnt = 0;
        end
        prevBusy = busyA;
      end
    end
  end

  initial begin
    // Reset then idle
    doReset();
    repeat (20) begin
      @(negedge clk);
      checkEq("rstBusy", {31'd0, busyA}, 32'd0);
      checkEq("rstCnt", {29'd0, cntA}, 32'd0);
      checkEq("rstOvf", {30'd0, ovfA, ovfB}, 32'd0);
      checkEq("rstLedB", {30'd0, led1B, led2B}, 32'd3);
    end

    // Single command: latency and exact hold length
    sendChar(8'h41, 1'b1);
    idleIn();
    checkEq("pushCnt", {29'd0, cntA}, 32'd1);
    checkEq("notYetBusy", {31'd0, busyA}, 32'd0);
    repeat (HOLD_A) begin
      @(negedge clk);
      checkEq("singleBusy", {31'd0, busyA}, 32'd1);
      checkEq("singleLed", {30'd0, led1A, led2A}, 32'd1);
    end
    @(negedge clk);
    checkEq("singleEnd", {29'd0, busyA, led1A, led2A}, 32'd3);

    // Back-to-back including an unknown character
    sendChar(8'h41, 1'b1);
    sendChar(8'h42, 1'b1);
    sendChar(8'h43, 1'b1);
    sendChar(8'h5A, 1'b1);
    idleIn();
    repeat (4 * HOLD_A + 5) @(negedge clk);
    checkEq("b2bDrained", expQ.size(), 32'd0);
    checkEq("b2bIdle", {31'd0, busyA}, 32'd0);

    // Resync: separate startFlag, then startFlag together with readFlag
    sendNib(4'h7);
    @(negedge clk);
    readFlag = 1'b0;
    startFlag = 1'b1;
    sendChar(8'h42, 1'b1);
    idleIn();
    repeat (HOLD_A + 4) @(negedge clk);
    sendNib(4'h7);
    @(negedge clk);
    startFlag = 1'b1;
    readFlag  = 1'b1;
    dataIn    = 4'h4;
    sendNib(4'h3);
    expQ.push_back(2'b00);
    idleIn();
    repeat (HOLD_A + 4) @(negedge clk);
    checkEq("resyncDrained", expQ.size(), 32'd0);
    checkEq("resyncCnt", {29'd0, cntA}, 32'd0);

    // Overflow on the long-hold instance
    doReset();
    monEn = 1'b0;
    sendChar(8'h41, 1'b0);
    sendChar(8'h42, 1'b0);
    sendChar(8'h43, 1'b0);
    sendChar(8'h41, 1'b0);
    sendChar(8'h42, 1'b0);
    sendChar(8'h43, 1'b0);
    idleIn();
    checkEq("ovfCnt", {29'd0, cntB}, 32'd4);
    checkEq("ovfFlag", {31'd0, ovfB}, 32'd1);
    checkEq("ovfLedA", {29'd0, busyB, led1B, led2B}, 32'd5);
    repeat (141) @(negedge clk);
    checkEq("ovfSlotB", {29'd0, busyB, led1B, led2B}, 32'd6);
    repeat (100) @(negedge clk);
    checkEq("ovfSlotC", {29'd0, busyB, led1B, led2B}, 32'd4);
    repeat (100) @(negedge clk);
    checkEq("ovfSlotA", {29'd0, busyB, led1B, led2B}, 32'd5);
    repeat (100) @(negedge clk);
    checkEq("ovfSlotB2", {29'd0, busyB, led1B, led2B}, 32'd6);
    repeat (100) @(negedge clk);
    checkEq("ovfDoneIdle", {29'd0, busyB, led1B, led2B}, 32'd3);
    checkEq("ovfDoneCnt", {29'd0, cntB}, 32'd0);
    checkEq("ovfSticky", {31'd0, ovfB}, 32'd1);
    doReset();
    checkEq("ovfCleared", {31'd0, ovfB}, 32'd0);

    // Reset in the middle of a hold with two characters queued
    sendChar(8'h41, 1'b1);
    sendChar(8'h42, 1'b0);
    sendChar(8'h43, 1'b0);
    idleIn();
    checkEq("midQueued", {29'd0, cntA}, 32'd2);
    checkEq("midBusy", {31'd0, busyA}, 32'd1);
    monEn  = 1'b0;
    resetN = 1'b0;
    @(negedge clk);
    checkEq("midRstLed", {29'd0, busyA, led1A, led2A}, 32'd3);
    checkEq("midRstCnt", {29'd0, cntA}, 32'd0);
    resetN = 1'b1;
    expQ.delete();
    slotCnt  = 0;
    prevBusy = 1'b0;
    monEn    = 1'b1;
    repeat (20) begin
      @(negedge clk);
      checkEq("midNoReplay", {31'd0, busyA}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
